// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and encodings for the multicycle main controller
// State enumeration, opcode constants, datapath select encodings and the control word.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  typedef struct packed {
    logic       memreq;
    logic       adrsrc;
    logic       irwrite;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/mc_maindec_if.sv
// rtl/mc_maindec_if.sv - controller-to-datapath signal bundle
// master = controller side, slave = datapath/memory side.
interface mc_maindec_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             MemReady;
  logic             MemReq;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCUpdate;
  logic             Branch;
  logic             RegWrite;
  logic             MemWrite;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       ResultSrc;
  logic             Trap;
  logic [CNT_W-1:0] InstRet;

  modport master (
    input  op, MemReady,
    output MemReq, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Trap, InstRet
  );

  modport slave (
    output op, MemReady,
    input  MemReq, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Trap, InstRet
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational state to control word decode
// FETCH raises irwrite/pcupdate unconditionally; the top gates them with memory ready.
module mc_ctrl_outdec
  import rv_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.memreq    = 1'b1;
        cw.irwrite   = 1'b1;
        cw.pcupdate  = 1'b1;
        cw.alusrca   = SRCA_PC;
        cw.alusrcb   = SRCB_FOUR;
        cw.aluop     = ALUOP_ADD;
        cw.resultsrc = RES_ALURESULT;
      end
      S_DECODE: begin
        cw.alusrca = SRCA_OLDPC;
        cw.alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        cw.alusrca = SRCA_A;
        cw.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        cw.memreq = 1'b1;
        cw.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        cw.resultsrc = RES_DATA;
        cw.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        cw.memreq   = 1'b1;
        cw.adrsrc   = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_EXECR: begin
        cw.alusrca = SRCA_A;
        cw.alusrcb = SRCB_WD;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        cw.alusrca = SRCA_A;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.resultsrc = RES_ALUOUT;
        cw.regwrite  = 1'b1;
      end
      S_BEQ: begin
        cw.alusrca = SRCA_A;
        cw.alusrcb = SRCB_WD;
        cw.aluop   = ALUOP_SUB;
        cw.branch  = 1'b1;
      end
      // ALUOut still holds the target computed in DECODE; the ALU now forms the link value.
      S_JAL: begin
        cw.alusrca  = SRCA_OLDPC;
        cw.alusrcb  = SRCB_FOUR;
        cw.pcupdate = 1'b1;
      end
      S_JALR: begin
        cw.alusrca   = SRCA_A;
        cw.alusrcb   = SRCB_IMM;
        cw.resultsrc = RES_ALURESULT;
        cw.pcupdate  = 1'b1;
      end
      S_JLINK: begin
        cw.alusrca = SRCA_OLDPC;
        cw.alusrcb = SRCB_FOUR;
      end
      S_LUI: begin
        cw.resultsrc = RES_IMMEXT;
        cw.regwrite  = 1'b1;
      end
      S_AUIPC: begin
        cw.alusrca = SRCA_OLDPC;
        cw.alusrcb = SRCB_IMM;
      end
      S_TRAP: begin
        cw.trap = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// rtl/mc_maindec.sv - multicycle RISC-V main control FSM
// Holds state, next-state decode, memory-ready gating, reset gating and the retire counter.
module mc_maindec
  import rv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EXT_U         = 1'b1,
  parameter int CNT_W         = 32
) (
  input logic          clk,
  input logic          reset,
  mc_maindec_if.master bus
);

  state_t           state, state_n;
  ctrl_t            cw;
  logic             ready;
  logic [CNT_W-1:0] instret;

  assign ready = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:    if (ready) state_n = S_DECODE;
      S_DECODE: begin
        state_n = S_TRAP;
        case (bus.op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_RTYPE:          state_n = S_EXECR;
          OP_ITYPE:          state_n = S_EXECI;
          OP_BRANCH:         state_n = S_BEQ;
          OP_JAL:            state_n = S_JAL;
          OP_JALR:           if (EXT_U) state_n = S_JALR;
          OP_LUI:            if (EXT_U) state_n = S_LUI;
          OP_AUIPC:          if (EXT_U) state_n = S_AUIPC;
          default:           state_n = S_TRAP;
        endcase
      end
      S_MEMADR:   state_n = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ready) state_n = S_MEMWB;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE: if (ready) state_n = S_FETCH;
      S_EXECR:    state_n = S_ALUWB;
      S_EXECI:    state_n = S_ALUWB;
      S_ALUWB:    state_n = S_FETCH;
      S_BEQ:      state_n = S_FETCH;
      S_JAL:      state_n = S_ALUWB;
      S_JALR:     state_n = S_JLINK;
      S_JLINK:    state_n = S_ALUWB;
      S_LUI:      state_n = S_FETCH;
      S_AUIPC:    state_n = S_ALUWB;
      S_TRAP:     state_n = S_TRAP;
      default:    state_n = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that returns the FSM to FETCH.
  always_ff @(posedge clk) begin
    if (reset)
      instret <= '0;
    else if (state != S_FETCH && state_n == S_FETCH)
      instret <= instret + CNT_W'(1);
  end

  mc_ctrl_outdec u_outdec (
    .state (state),
    .cw    (cw)
  );

  assign bus.MemReq    = cw.memreq;
  assign bus.AdrSrc    = cw.adrsrc;
  assign bus.ALUSrcA   = cw.alusrca;
  assign bus.ALUSrcB   = cw.alusrcb;
  assign bus.ALUOp     = cw.aluop;
  assign bus.ResultSrc = cw.resultsrc;
  assign bus.InstRet   = instret;

  // Architectural writes are suppressed combinationally so a mid-instruction reset cannot commit.
  assign bus.IRWrite   = cw.irwrite & ready & ~reset;
  assign bus.PCUpdate  = cw.pcupdate & (ready | (state != S_FETCH)) & ~reset;
  assign bus.Branch    = cw.branch & ~reset;
  assign bus.RegWrite  = cw.regwrite & ~reset;
  assign bus.MemWrite  = cw.memwrite & ~reset;
  assign bus.Trap      = cw.trap & ~reset;

endmodule

// File: tb/tb_mc_maindec.sv
// tb/tb_mc_maindec.sv - self-checking bench for mc_maindec
// u0: handshake on, U-type on, 32-bit counter; u1: no handshake, U-type off, 4-bit counter.
module tb_mc_maindec;
  import rv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic r0, r1;
  always #5 clk = ~clk;

  mc_maindec_if #(.CNT_W(32)) b0 ();
  mc_maindec_if #(.CNT_W(4))  b1 ();

  mc_maindec #(.MEM_HANDSHAKE(1'b1), .EXT_U(1'b1), .CNT_W(32)) u0 (.clk(clk), .reset(r0), .bus(b0));
  mc_maindec #(.MEM_HANDSHAKE(1'b0), .EXT_U(1'b0), .CNT_W(4))  u1 (.clk(clk), .reset(r1), .bus(b1));

  typedef struct packed {
    logic        memreq, adrsrc, irwrite, pcupdate, branch, regwrite, memwrite, trap;
    logic [1:0]  alusrca, alusrcb, aluop, resultsrc;
    logic [31:0] instret;
  } smp_t;

  int   npass = 0, ntot = 0, nfail = 0;
  int   m0 = 0, m1 = 0;
  int   wf_left = 0, wm_left = 0;
  smp_t trace[$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic smp_t sample(input int d);
    smp_t s;
    if (d == 0)
      s = '{b0.MemReq, b0.AdrSrc, b0.IRWrite, b0.PCUpdate, b0.Branch, b0.RegWrite, b0.MemWrite,
            b0.Trap, b0.ALUSrcA, b0.ALUSrcB, b0.ALUOp, b0.ResultSrc, b0.InstRet};
    else
      s = '{b1.MemReq, b1.AdrSrc, b1.IRWrite, b1.PCUpdate, b1.Branch, b1.RegWrite, b1.MemWrite,
            b1.Trap, b1.ALUSrcA, b1.ALUSrcB, b1.ALUOp, b1.ResultSrc, 32'(b1.InstRet)};
    return s;
  endfunction

  function automatic smp_t tr(input int i);
    smp_t z = '0;
    if (i < trace.size()) return trace[i];
    return z;
  endfunction

  function automatic bit is_fetch(input smp_t s);
    return s.memreq && !s.adrsrc;
  endfunction

  // Reference timing from the instruction class, not from any state walk.
  function automatic int base_lat(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_JALR:  return 5;
      OP_BRANCH, OP_LUI: return 3;
      default:           return 4;
    endcase
  endfunction

  task automatic set_op(input int d, input logic [6:0] op);
    if (d == 0) b0.op = op; else b1.op = op;
  endtask

  task automatic set_rst(input int d, input logic v);
    if (d == 0) r0 = v; else r1 = v;
  endtask

  // Called at a negedge: drive MemReady, sample outputs, advance to next negedge.
  task automatic step(input int d, output smp_t s);
    logic mr;
    s = sample(d);
    if (s.memreq && !s.adrsrc) begin
      if (wf_left > 0) begin mr = 1'b0; wf_left--; end else mr = 1'b1;
    end else if (s.memreq) begin
      if (wm_left > 0) begin mr = 1'b0; wm_left--; end else mr = 1'b1;
    end else
      mr = 1'($urandom_range(0, 1));
    if (d == 0) b0.MemReady = mr; else b1.MemReady = mr;
    #1 s = sample(d);
    @(negedge clk);
  endtask

  task automatic do_reset(input int d, input int ncyc);
    smp_t s;
    set_rst(d, 1'b1);
    for (int i = 0; i < ncyc; i++) begin
      #1 s = sample(d);
      check("rst_enables_low", {s.regwrite, s.memwrite, s.pcupdate, s.irwrite, s.branch, s.trap}, 0);
      @(negedge clk);
    end
    set_rst(d, 1'b0);
    #1 s = sample(d);
    check("rst_instret", s.instret, 0);
    check("rst_trap", s.trap, 0);
    check("rst_in_fetch", is_fetch(s), 1);
    if (d == 0) m0 = 0; else m1 = 0;
  endtask

  task automatic run_instr(input int d, input logic [6:0] op, input int wf, input int wm);
    smp_t s;
    int   n = 0, rw = 0, mw = 0, pc = 0, br = 0, ir = 0, exp_lat;
    bit   left = 0, hs = (d == 0), mem = (op == OP_LOAD || op == OP_STORE);
    set_op(d, op);
    wf_left = wf;
    wm_left = wm;
    trace.delete();
    while (n < 60) begin
      if (left && is_fetch(sample(d))) break;
      step(d, s);
      trace.push_back(s);
      n++;
      if (!is_fetch(s)) left = 1;
      rw += int'(s.regwrite); mw += int'(s.memwrite); pc += int'(s.pcupdate);
      br += int'(s.branch);   ir += int'(s.irwrite);
    end
    if (d == 0) m0++; else m1++;
    exp_lat = base_lat(op) + (hs ? wf + (mem ? wm : 0) : 0);
    check($sformatf("latency op=%02h", op), n, exp_lat);
    check($sformatf("regwrite_cnt op=%02h", op), rw, (op == OP_STORE || op == OP_BRANCH) ? 0 : 1);
    check($sformatf("memwrite_cnt op=%02h", op), mw, (op == OP_STORE) ? 1 + (hs ? wm : 0) : 0);
    check($sformatf("pcupdate_cnt op=%02h", op), pc, (op == OP_JAL || op == OP_JALR) ? 2 : 1);
    check($sformatf("branch_cnt op=%02h", op), br, (op == OP_BRANCH) ? 1 : 0);
    check($sformatf("irwrite_cnt op=%02h", op), ir, 1);
    #1 check($sformatf("instret op=%02h", op), sample(d).instret, (d == 0) ? m0 : (m1 % 16));
  endtask

  task automatic run_trap(input int d, input logic [6:0] op);
    smp_t s;
    int   n = 0, held = 0, req = 0;
    int   ret0 = (d == 0) ? m0 : (m1 % 16);
    set_op(d, op);
    wf_left = 0;
    wm_left = 0;
    s = '0;
    while (n < 10 && !s.trap) begin
      step(d, s);
      n++;
    end
    check($sformatf("trap_entry op=%02h", op), n, 3);
    for (int i = 0; i < 20; i++) begin
      step(d, s);
      held += int'(s.trap);
      req  += int'(s.memreq | s.regwrite | s.memwrite | s.pcupdate | s.irwrite | s.branch);
    end
    check("trap_held_20", held, 20);
    check("trap_enables_low", req, 0);
    #1 check("trap_instret_frozen", sample(d).instret, ret0);
    do_reset(d, 1);
  endtask

  initial begin
    smp_t s;
    logic [6:0] ops0[9] = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    logic [6:0] ops1[6] = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
    r0 = 1'b1; r1 = 1'b1;
    b0.op = OP_RTYPE; b1.op = OP_RTYPE;
    b0.MemReady = 1'b0; b1.MemReady = 1'b0;
    @(negedge clk);

    // No-handshake R-type straight out of a 2-cycle reset.
    do_reset(1, 2);
    run_instr(1, OP_RTYPE, 0, 0);
    check("rtype_irwrite_c0", tr(0).irwrite, 1);
    check("rtype_regwrite_c3", tr(3).regwrite, 1);
    check("rtype_aluop_c2", tr(2).aluop, ALUOP_FUNCT);

    do_reset(0, 2);
    // lw with 3 memory wait cycles.
    run_instr(0, OP_LOAD, 0, 3);
    begin
      int rd = 0;
      foreach (trace[i]) rd += int'(trace[i].memreq && trace[i].adrsrc);
      check("lw_memread_cycles", rd, 4);
    end
    check("lw_memadr_srca", tr(2).alusrca, SRCA_A);
    check("lw_memwb_result", tr(7).resultsrc, RES_DATA);

    run_instr(0, OP_STORE, 0, 2);
    check("sw_memwrite_c3", tr(3).memwrite & tr(4).memwrite & tr(5).memwrite, 1);

    run_instr(0, OP_JALR, 1, 0);
    check("jalr_pcupdate", tr(3).pcupdate, 1);
    check("jalr_resultsrc", tr(3).resultsrc, RES_ALURESULT);
    check("jlink_srca", tr(4).alusrca, SRCA_OLDPC);
    check("jlink_srcb", tr(4).alusrcb, SRCB_FOUR);
    check("jalr_wb_regwrite", tr(5).regwrite, 1);

    run_instr(0, OP_LUI, 0, 0);
    check("lui_resultsrc", tr(2).resultsrc, RES_IMMEXT);
    run_instr(0, OP_BRANCH, 0, 0);
    check("beq_aluop", tr(2).aluop, ALUOP_SUB);

    for (int i = 0; i < 40; i++)
      run_instr(0, ops0[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3));

    run_trap(0, 7'h7F);

    // Reset landing in the middle of a stalled store.
    set_op(0, OP_STORE);
    wf_left = 0;
    wm_left = 9;
    s = '0;
    for (int i = 0; i < 12 && !s.memwrite; i++) step(0, s);
    check("sw_reached_memwrite", s.memwrite, 1);
    do_reset(0, 1);

    do_reset(1, 1);
    run_trap(1, OP_JALR);
    run_trap(1, OP_LUI);

    for (int i = 0; i < 17; i++) run_instr(1, OP_RTYPE, 0, 0);
    #1 check("instret_wrap", sample(1).instret, 1);

    for (int i = 0; i < 20; i++) run_instr(1, ops1[$urandom_range(0, 5)], 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
